// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the measurement-link UART receiver
// and its report-frame assembler.
package uart_pkg;

  localparam int unsigned BPS_DEFAULT   = 868;
  localparam int unsigned BPS_2_DEFAULT = 434;

  localparam int unsigned FRAME_LEN = 18;
  localparam int unsigned IDX_W     = 5;

  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  localparam logic [IDX_W-1:0] IDX_LF = IDX_W'(FRAME_LEN - 2);
  localparam logic [IDX_W-1:0] IDX_CR = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_CHECK,
    BIT_STOP
  } bit_state_e;

  typedef enum logic [1:0] {
    ASM_HUNT,
    ASM_HUNT_CR,
    ASM_COLLECT
  } asm_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// Serial byte receiver: input synchronizer, start-edge detect and an 11-bit
// character FSM (start, 8 data LSB first, check bit 0, stop bit 1).
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BPS   = BPS_DEFAULT,
  parameter int unsigned BPS_2 = BPS_2_DEFAULT
) (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic       uart_rx_1,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       err_check,
  output logic       err_frame
);

  localparam int unsigned      CNT_W    = $clog2(BPS + 1);
  localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(BPS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BPS_2);

  logic             sync1_q, sync2_q, dly_q;
  bit_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             chk_bad_q, chk_bad_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             err_check_q, err_check_d;
  logic             err_frame_q, err_frame_d;

  logic fall;
  logic sample;

  assign fall   = dly_q & ~sync2_q;
  assign sample = (cnt_q == CNT_MID);

  always_ff @(posedge clk_100M) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      dly_q       <= 1'b1;
      state_q     <= BIT_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      chk_bad_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      err_check_q <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      sync1_q     <= uart_rx_1;
      sync2_q     <= sync1_q;
      dly_q       <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      chk_bad_q   <= chk_bad_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      err_check_q <= err_check_d;
      err_frame_q <= err_frame_d;
    end
  end

  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latches are inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    chk_bad_d   = chk_bad_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    err_check_d = 1'b0;
    err_frame_d = 1'b0;

    // Counter free-runs from the start edge; every sample lands on CNT_MID.
    if (state_q != BIT_IDLE) begin
      cnt_d = (cnt_q == CNT_WRAP) ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      BIT_IDLE: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = BIT_START;
        end
      end
      BIT_START: begin
        if (sample) begin
          if (sync2_q) begin
            state_d = BIT_IDLE;
          end else begin
            bit_idx_d = '0;
            chk_bad_d = 1'b0;
            state_d   = BIT_DATA;
          end
        end
      end
      BIT_DATA: begin
        if (sample) begin
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = BIT_CHECK;
          end
        end
      end
      BIT_CHECK: begin
        if (sample) begin
          chk_bad_d = sync2_q;
          state_d   = BIT_STOP;
        end
      end
      BIT_STOP: begin
        if (sample) begin
          // Back to IDLE right away so a start edge half a bit later is seen.
          state_d = BIT_IDLE;
          if (!sync2_q) begin
            err_frame_d = 1'b1;
          end else if (chk_bad_q) begin
            err_check_d = 1'b1;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
          end
        end
      end
      default: begin
        state_d = BIT_IDLE;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign err_check = err_check_q;
  assign err_frame = err_frame_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Measurement-link receiver: hunts for the LF CR delimiter, collects the four
// little-endian 32-bit counters and publishes them once the trailer checks out.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int unsigned BPS   = BPS_DEFAULT,
  parameter int unsigned BPS_2 = BPS_2_DEFAULT
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        uart_rx_1,
  output logic [31:0] cnt_clk,
  output logic [31:0] cnt_square,
  output logic [31:0] cnt_pulse,
  output logic [31:0] cnt_time,
  output logic        frame_valid,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        err_frame,
  output logic        err_check,
  output logic        err_trailer
);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_err_check;
  logic       byte_err_frame;

  uart_rx_byte #(
    .BPS   (BPS),
    .BPS_2 (BPS_2)
  ) u_rx_byte (
    .clk_100M  (clk_100M),
    .rst       (rst),
    .uart_rx_1 (uart_rx_1),
    .rx_data   (byte_data),
    .rx_valid  (byte_valid),
    .err_check (byte_err_check),
    .err_frame (byte_err_frame)
  );

  asm_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0][31:0] shadow_q;
  logic             shadow_we;
  logic             publish;
  logic             trailer_bad;

  logic [31:0] cnt_clk_q, cnt_square_q, cnt_pulse_q, cnt_time_q;
  logic        frame_valid_q;
  logic        err_trailer_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_we   = 1'b0;
    publish     = 1'b0;
    trailer_bad = 1'b0;

    if (byte_err_check || byte_err_frame) begin
      state_d = ASM_HUNT;
    end else if (byte_valid) begin
      unique case (state_q)
        ASM_HUNT: begin
          if (byte_data == LF) state_d = ASM_HUNT_CR;
        end
        ASM_HUNT_CR: begin
          if (byte_data == CR) begin
            state_d = ASM_COLLECT;
            idx_d   = '0;
          end else if (byte_data != LF) begin
            state_d = ASM_HUNT;
          end
        end
        ASM_COLLECT: begin
          if (idx_q < IDX_LF) begin
            shadow_we = 1'b1;
            idx_d     = idx_q + IDX_W'(1);
          end else if (idx_q == IDX_LF) begin
            if (byte_data == LF) begin
              idx_d = IDX_CR;
            end else begin
              trailer_bad = 1'b1;
              state_d     = ASM_HUNT;
            end
          end else begin
            // A good CR closes this frame and opens the next one directly.
            if (byte_data == CR) begin
              publish = 1'b1;
              idx_d   = '0;
            end else begin
              trailer_bad = 1'b1;
              state_d     = ASM_HUNT;
            end
          end
        end
        default: begin
          state_d = ASM_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q       <= ASM_HUNT;
      idx_q         <= '0;
      cnt_clk_q     <= '0;
      cnt_square_q  <= '0;
      cnt_pulse_q   <= '0;
      cnt_time_q    <= '0;
      frame_valid_q <= 1'b0;
      err_trailer_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_valid_q <= publish;
      err_trailer_q <= trailer_bad;
      if (publish) begin
        cnt_clk_q    <= shadow_q[0];
        cnt_square_q <= shadow_q[1];
        cnt_pulse_q  <= shadow_q[2];
        cnt_time_q   <= shadow_q[3];
      end
    end
  end

  // NOTE: shadow words are not reset; nothing is published until all 16 bytes are rewritten.
  always_ff @(posedge clk_100M) begin
    if (shadow_we) begin
      shadow_q[idx_q[3:2]][{idx_q[1:0], 3'b000} +: 8] <= byte_data;
    end
  end

  assign cnt_clk     = cnt_clk_q;
  assign cnt_square  = cnt_square_q;
  assign cnt_pulse   = cnt_pulse_q;
  assign cnt_time    = cnt_time_q;
  assign frame_valid = frame_valid_q;
  assign err_trailer = err_trailer_q;
  assign rx_data     = byte_data;
  assign rx_valid    = byte_valid;
  assign err_check   = byte_err_check;
  assign err_frame   = byte_err_frame;

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- UART receiver for the measurement link. It decodes the 11-bit character format used by the board transmitter: start, 8 data bits LSB first, check bit fixed 0, stop.
- Reassembles the 18-byte report frame: cnt_clk, cnt_square, cnt_pulse, cnt_time, each 32-bit little-endian, then 0x0A, 0x0D.
- Presents the four counters with a one-cycle frame strobe.
- Used on the host-side/loopback FPGA and in the system bench to check the measurement path end to end.

Parameters:
- BPS, 868: bit period is BPS+1 clk_100M cycles, 869 cycles ≈ 115200 baud at 100 MHz.
- BPS_2, 434: mid-bit sample offset from the detected start edge.

Ports:
- clk_100M  in  1  system clock, 100 MHz; single clock domain.
- rst  in  1  synchronous reset, active-high.
- uart_rx_1  in  1  serial line, asynchronous, idle high.
- cnt_clk  out  32  last good frame, word 0.
- cnt_square  out  32  last good frame, word 1.
- cnt_pulse  out  32  last good frame, word 2.
- cnt_time  out  32  last good frame, word 3.
- frame_valid  out  1  one-cycle pulse; outputs updated this cycle.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse per byte with good check and stop bits.
- err_frame  out  1  one-cycle pulse: stop bit sampled 0.
- err_check  out  1  one-cycle pulse: check bit sampled 1.
- err_trailer  out  1  one-cycle pulse: byte 16 ≠ 0x0A or byte 17 ≠ 0x0D.

Behaviour:
- Reset (rst high at a clock edge): all outputs 0, synchronizer bits 1, bit FSM IDLE, assembler HUNT, shadow registers discarded. This applies mid-byte and mid-frame; nothing partial is ever published.
- Input path: 2-FF synchronizer, then one delay register. A falling edge is synced high→low.
- Bit FSM states: IDLE, START, DATA, CHECK, STOP.
  - IDLE: on a falling edge, clear the bit counter and go to START.
  - START: at count BPS_2, sample. If 1, the edge was a glitch: return to IDLE with no pulse. If 0, go to DATA.
  - Subsequent samples occur every BPS+1 cycles. The counter wraps at BPS.
  - DATA: 8 samples shifted into bit 7 (LSB first), then CHECK.
  - CHECK: one sample, expected 0. A mismatch is latched.
  - STOP: one sample, expected 1.
  - The cycle after the stop sample, exactly one of the following pulses: rx_valid, err_check, or err_frame. err_frame wins if both the check and stop bits are bad. rx_data is updated with rx_valid.
  - Then return to IDLE immediately, so a back-to-back start edge half a bit later is caught.
- Line held low (break): err_frame once. No further bytes until the line returns high and falls again.
- Assembler states: HUNT, HUNT_CR, COLLECT (index 0..17).
  - HUNT: 0x0A → HUNT_CR.
  - HUNT_CR: 0x0D → COLLECT, idx 0. 0x0A → stay in HUNT_CR. Anything else → HUNT.
  - COLLECT, idx 0–15: byte written to shadow word idx/4, byte lane idx%4.
  - COLLECT, idx 16: must be 0x0A. idx 17: must be 0x0D.
  - On a valid idx 17: the next cycle loads all four outputs from shadow, pulses frame_valid, and goes to COLLECT idx 0. No rehunt is needed on a continuous stream.
  - Trailer mismatch: err_trailer pulse, outputs unchanged, go to HUNT.
  - err_check or err_frame in any state: byte dropped, go to HUNT.
- Latency: frame_valid is 2 cycles after the stop-bit sample of the 0x0D byte.
- Outputs hold between good frames.

Decomposition:
- Package uart_pkg:
  - BPS and BPS_2 defaults
  - FRAME_LEN = 18
  - LF = 8'h0A, CR = 8'h0D
  - bit-FSM and assembler state encodings
- Sub-module uart_rx_byte: synchronizer, edge detect, bit FSM. Outputs rx_data, rx_valid, err_check, err_frame.
- Top uart_frame_rx: instantiates uart_rx_byte and contains the assembler and output registers.

Test Plan:
- Sync then frame: send 0A 0D, then bytes 00 E1 F5 05 E8 03 00 00 64 00 00 00 34 12 00 00 0A 0D → one frame_valid. Outputs: cnt_clk=32'h05F5E100, cnt_square=32'h000003E8, cnt_pulse=32'h00000064, cnt_time=32'h00001234.
- Continuous stream: three back-to-back frames with no idle gap, cnt_time values 1, 2, 3 → three frame_valid pulses 18×11×869 cycles apart; cnt_time steps 1→2→3; no error pulses.
- Glitch: 200-cycle low pulse on an idle line → no rx_valid, no error pulse, FSM back in IDLE; a following byte 0x55 is received correctly.
- Bad bits: byte with check bit 1 → err_check, assembler in HUNT. Byte with stop bit 0 → err_frame. Outputs unchanged in both cases; the next 0A 0D plus a frame recovers.
- Trailer: frame ending 0A 0B → err_trailer, no frame_valid, previous outputs retained.
- Reset: assert rst for 1 cycle during bit 4 of byte 9 → all outputs 0, no pulses. A subsequent full sync plus frame is received correctly.
